// File: rtl/mem_access_pkg.sv
// ============================================================================
// lca_pkg : shared encodings and widths for the LCA memory-access stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package lca_pkg;

  localparam int WORD_W = 16;
  localparam int REG_AW = 3;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_SW   = 3'd2,
    MEM_LM   = 3'd3,
    MEM_SM   = 3'd4
  } mem_op_e;

  typedef enum logic [0:0] {
    MA_IDLE  = 1'b0,
    MA_MULTI = 1'b1
  } ma_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_access_if.sv
// ============================================================================
// mem_access_if : pipeline, register-file and data-memory signals of mem_access
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_access_if;
  import lca_pkg::*;

  logic              validIn;
  logic [2:0]        memOp;
  logic [WORD_W-1:0] ALUIn;
  logic [WORD_W-1:0] storeData;
  logic [7:0]        regList;
  logic [REG_AW-1:0] destIn;
  logic              regWrIn;
  logic [REG_AW-1:0] smRegAddr;
  logic [WORD_W-1:0] smRegData;
  logic [WORD_W-1:0] memAddr;
  logic [WORD_W-1:0] memWrData;
  logic              memWrEn;
  logic [WORD_W-1:0] memRdData;
  logic              stall;
  logic [WORD_W-1:0] MemData;
  logic [WORD_W-1:0] ALUOut;
  logic [REG_AW-1:0] destOut;
  logic              regWrOut;
  logic              validOut;

  modport slave (
    input  validIn, memOp, ALUIn, storeData, regList, destIn, regWrIn,
           smRegData, memRdData,
    output smRegAddr, memAddr, memWrData, memWrEn, stall,
           MemData, ALUOut, destOut, regWrOut, validOut
  );

  modport master (
    output validIn, memOp, ALUIn, storeData, regList, destIn, regWrIn,
           smRegData, memRdData,
    input  smRegAddr, memAddr, memWrData, memWrEn, stall,
           MemData, ALUOut, destOut, regWrOut, validOut
  );

endinterface

`default_nettype wire

// File: rtl/mem_access_prio_enc8.sv
// ============================================================================
// prio_enc8 : lowest-set-bit encoder with empty and single-bit flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module prio_enc8 (
  input  logic [7:0] mask_i,
  output logic [2:0] idx_o,
  output logic       none_o,
  output logic       single_o
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx_o = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_i[i]) idx_o = 3'(i);
    end
  end

  assign none_o   = (mask_i == 8'd0);
  assign single_o = !none_o && ((mask_i & (mask_i - 8'd1)) == 8'd0);

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// mem_access : LCA memory stage - LW/SW plus register-per-cycle LM/SM sequencing
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access
  import lca_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);

  ma_state_e         state_q, state_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic [7:0]        mask_q, mask_d;
  logic [2:0]        k_q, k_d;
  logic              isSm_q, isSm_d;
  logic [WORD_W-1:0] memData_q, memData_d;
  logic [WORD_W-1:0] aluOut_q, aluOut_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              regWr_q, regWr_d;
  logic              valid_q, valid_d;

  logic [7:0]        sel_mask;
  logic [7:0]        low_bit;
  logic [2:0]        pe_idx;
  logic              pe_none;
  logic              pe_single;
  logic              wr_en_raw;
  logic              stall_raw;

  assign sel_mask = (state_q == MA_IDLE) ? bus.regList : mask_q;
  assign low_bit  = 8'd1 << pe_idx;

  prio_enc8 u_prio (
    .mask_i   (sel_mask),
    .idx_o    (pe_idx),
    .none_o   (pe_none),
    .single_o (pe_single)
  );

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    mask_d        = mask_q;
    k_d           = k_q;
    isSm_d        = isSm_q;
    memData_d     = memData_q;
    aluOut_d      = aluOut_q;
    dest_d        = dest_q;
    regWr_d       = 1'b0;
    valid_d       = 1'b0;
    bus.memAddr   = bus.ALUIn;
    bus.memWrData = bus.storeData;
    bus.smRegAddr = pe_idx;
    wr_en_raw     = 1'b0;
    stall_raw     = 1'b0;

    if (state_q == MA_IDLE) begin
      aluOut_d = bus.ALUIn;
      if (bus.validIn) begin
        valid_d = 1'b1;
        dest_d  = bus.destIn;
        regWr_d = bus.regWrIn;
        case (bus.memOp)
          MEM_LW: memData_d = bus.memRdData;
          MEM_SW: begin
            wr_en_raw = 1'b1;
            regWr_d   = 1'b0;
          end
          MEM_LM, MEM_SM: begin
            regWr_d = 1'b0;
            if (!pe_none) begin
              dest_d = pe_idx;
              if (bus.memOp == MEM_LM) begin
                memData_d = bus.memRdData;
                regWr_d   = 1'b1;
              end else begin
                bus.memWrData = bus.smRegData;
                wr_en_raw     = 1'b1;
              end
              // Offset 0 is consumed now, so the residual walk starts at k=1.
              if (!pe_single) begin
                stall_raw = 1'b1;
                state_d   = MA_MULTI;
                base_d    = bus.ALUIn;
                mask_d    = bus.regList & ~low_bit;
                k_d       = 3'd1;
                isSm_d    = (bus.memOp == MEM_SM);
              end
            end
          end
          default: ;
        endcase
      end
    end else begin
      bus.memAddr = base_q + {{(WORD_W-3){1'b0}}, k_q};
      valid_d     = 1'b1;
      dest_d      = pe_idx;
      if (isSm_q) begin
        bus.memWrData = bus.smRegData;
        wr_en_raw     = 1'b1;
      end else begin
        memData_d = bus.memRdData;
        regWr_d   = 1'b1;
      end
      mask_d = mask_q & ~low_bit;
      k_d    = k_q + 3'd1;
      if (pe_single) begin
        state_d = MA_IDLE;
        mask_d  = 8'd0;
        k_d     = 3'd0;
      end else begin
        stall_raw = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MA_IDLE;
      base_q    <= '0;
      mask_q    <= '0;
      k_q       <= '0;
      isSm_q    <= 1'b0;
      memData_q <= '0;
      aluOut_q  <= '0;
      dest_q    <= '0;
      regWr_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      mask_q    <= mask_d;
      k_q       <= k_d;
      isSm_q    <= isSm_d;
      memData_q <= memData_d;
      aluOut_q  <= aluOut_d;
      dest_q    <= dest_d;
      regWr_q   <= regWr_d;
      valid_q   <= valid_d;
    end
  end

  // Reset gating keeps an aborted SM from writing during the reset window.
  assign bus.memWrEn  = wr_en_raw & reset;
  assign bus.stall    = stall_raw & reset;
  assign bus.MemData  = memData_q;
  assign bus.ALUOut   = aluOut_q;
  assign bus.destOut  = dest_q;
  assign bus.regWrOut = regWr_q;
  assign bus.validOut = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// tb_mem_access : directed self-checking bench for mem_access
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access;
  import lca_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  mem_access_if bus ();

  mem_access dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:7];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.memWrEn) mem[bus.memAddr] <= bus.memWrData;
  end

  assign bus.memRdData = mem[bus.memAddr];
  assign bus.smRegData = rf[bus.smRegAddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [7:0] rl,
                       input logic [2:0] dst, input logic rw);
    bus.validIn = v; bus.memOp = op; bus.ALUIn = alu; bus.storeData = sd;
    bus.regList = rl; bus.destIn = dst; bus.regWrIn = rw;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lm_dat [4];
    logic [2:0]  lm_dst [4];
    logic        lm_stl [4];
    logic [15:0] sm_adr [3];

    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    reset = 1'b0;
    drive(1'b0, MEM_NONE, 16'h0, 16'h0, 8'h0, 3'd0, 1'b0);
    tick();

    preload(16'h0040, 16'hBEEF);
    preload(16'h0041, 16'h1111);
    preload(16'h0042, 16'h2222);
    preload(16'h0043, 16'h3333);
    preload(16'h0100, 16'h0000);
    for (int i = 0; i < 8; i++) preload(16'h0300 + 16'(i), 16'hD000 + 16'(i));

    check("rst_MemData",  bus.MemData,  0);
    check("rst_ALUOut",   bus.ALUOut,   0);
    check("rst_destOut",  bus.destOut,  0);
    check("rst_regWrOut", bus.regWrOut, 0);
    check("rst_validOut", bus.validOut, 0);
    check("rst_stall",    bus.stall,    0);
    reset = 1'b1;
    tick();

    // LW
    drive(1'b1, MEM_LW, 16'h0040, 16'h0, 8'h0, 3'd3, 1'b1);
    #1;
    check("lw_addr",  bus.memAddr, 16'h0040);
    check("lw_stall", bus.stall, 0);
    check("lw_wren",  bus.memWrEn, 0);
    tick();
    check("lw_MemData",  bus.MemData, 16'hBEEF);
    check("lw_destOut",  bus.destOut, 3);
    check("lw_regWrOut", bus.regWrOut, 1);
    check("lw_validOut", bus.validOut, 1);
    check("lw_ALUOut",   bus.ALUOut, 16'h0040);

    // SW
    drive(1'b1, MEM_SW, 16'h0100, 16'h1234, 8'h0, 3'd1, 1'b1);
    #1;
    check("sw_wren",  bus.memWrEn, 1);
    check("sw_addr",  bus.memAddr, 16'h0100);
    check("sw_wdata", bus.memWrData, 16'h1234);
    tick();
    check("sw_mem",      mem[16'h0100], 16'h1234);
    check("sw_regWrOut", bus.regWrOut, 0);
    check("sw_validOut", bus.validOut, 1);
    drive(1'b0, MEM_NONE, 16'h0, 16'h0, 8'h0, 3'd0, 1'b0);
    #1;
    check("sw_wren_off", bus.memWrEn, 0);
    tick();

    // Invalid SW must not write
    drive(1'b0, MEM_SW, 16'h0100, 16'h5555, 8'h0, 3'd2, 1'b1);
    #1;
    check("inv_wren", bus.memWrEn, 0);
    tick();
    check("inv_validOut", bus.validOut, 0);
    check("inv_regWrOut", bus.regWrOut, 0);
    check("inv_mem",      mem[16'h0100], 16'h1234);

    // Undefined memOp 5 acts as a plain pass-through
    drive(1'b1, 3'd5, 16'h0055, 16'h9999, 8'hFF, 3'd2, 1'b1);
    #1;
    check("op5_wren", bus.memWrEn, 0);
    tick();
    check("op5_ALUOut",   bus.ALUOut, 16'h0055);
    check("op5_destOut",  bus.destOut, 2);
    check("op5_regWrOut", bus.regWrOut, 1);

    // LM 0xA5 from 0x0040
    lm_dat = '{16'hBEEF, 16'h1111, 16'h2222, 16'h3333};
    lm_dst = '{3'd0, 3'd2, 3'd5, 3'd7};
    lm_stl = '{1'b1, 1'b1, 1'b1, 1'b0};
    drive(1'b1, MEM_LM, 16'h0040, 16'h0, 8'hA5, 3'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("lm_stall", bus.stall, lm_stl[i]);
      check("lm_addr",  bus.memAddr, 16'h0040 + 16'(i));
      tick();
      check("lm_destOut",  bus.destOut, lm_dst[i]);
      check("lm_MemData",  bus.MemData, lm_dat[i]);
      check("lm_regWrOut", bus.regWrOut, 1);
      check("lm_validOut", bus.validOut, 1);
    end
    drive(1'b0, MEM_NONE, 16'h0, 16'h0, 8'h0, 3'd0, 1'b0);
    tick();
    check("lm_done_valid", bus.validOut, 0);

    // SM 0x07 wrapping past 0xFFFF
    rf[0] = 16'h000A; rf[1] = 16'h000B; rf[2] = 16'h000C;
    sm_adr = '{16'hFFFE, 16'hFFFF, 16'h0000};
    drive(1'b1, MEM_SM, 16'hFFFE, 16'h0, 8'h07, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("smw_addr",  bus.memAddr, sm_adr[i]);
      check("smw_wren",  bus.memWrEn, 1);
      check("smw_stall", bus.stall, (i < 2) ? 1 : 0);
      tick();
      check("smw_regWrOut", bus.regWrOut, 0);
      check("smw_validOut", bus.validOut, 1);
    end
    drive(1'b0, MEM_NONE, 16'h0, 16'h0, 8'h0, 3'd0, 1'b0);
    tick();
    check("smw_fffe", mem[16'hFFFE], 16'h000A);
    check("smw_ffff", mem[16'hFFFF], 16'h000B);
    check("smw_0000", mem[16'h0000], 16'h000C);

    // SM single bit R7
    rf[7] = 16'h7777;
    drive(1'b1, MEM_SM, 16'h0200, 16'h0, 8'h80, 3'd0, 1'b0);
    #1;
    check("sm1_stall",  bus.stall, 0);
    check("sm1_rdaddr", bus.smRegAddr, 7);
    check("sm1_wren",   bus.memWrEn, 1);
    tick();
    check("sm1_mem",      mem[16'h0200], 16'h7777);
    check("sm1_validOut", bus.validOut, 1);
    drive(1'b0, MEM_NONE, 16'h0, 16'h0, 8'h0, 3'd0, 1'b0);
    #1;
    check("sm1_stall_after", bus.stall, 0);
    tick();
    check("sm1_valid_after", bus.validOut, 0);

    // LM with empty list
    drive(1'b1, MEM_LM, 16'h0040, 16'h0, 8'h00, 3'd4, 1'b1);
    #1;
    check("lm0_stall", bus.stall, 0);
    check("lm0_wren",  bus.memWrEn, 0);
    tick();
    check("lm0_validOut", bus.validOut, 1);
    check("lm0_regWrOut", bus.regWrOut, 0);
    drive(1'b0, MEM_NONE, 16'h0, 16'h0, 8'h0, 3'd0, 1'b0);
    tick();

    // SM 0xFF aborted by reset after three transfers
    for (int i = 0; i < 8; i++) rf[i] = 16'h5000 + 16'(i);
    drive(1'b1, MEM_SM, 16'h0300, 16'h0, 8'hFF, 3'd0, 1'b0);
    tick(); tick(); tick();
    #1;
    check("abt_pre_stall", bus.stall, 1);
    reset = 1'b0;
    #1;
    check("abt_MemData",  bus.MemData, 0);
    check("abt_ALUOut",   bus.ALUOut, 0);
    check("abt_destOut",  bus.destOut, 0);
    check("abt_regWrOut", bus.regWrOut, 0);
    check("abt_validOut", bus.validOut, 0);
    check("abt_stall",    bus.stall, 0);
    check("abt_wren",     bus.memWrEn, 0);
    tick(); tick();
    for (int i = 0; i < 3; i++)
      check("abt_written", mem[16'h0300 + 16'(i)], 16'h5000 + 16'(i));
    for (int i = 3; i < 8; i++)
      check("abt_untouched", mem[16'h0300 + 16'(i)], 16'hD000 + 16'(i));
    drive(1'b1, MEM_LW, 16'h0040, 16'h0, 8'h0, 3'd6, 1'b1);
    reset = 1'b1;
    #1;
    check("post_stall", bus.stall, 0);
    tick();
    check("post_MemData",  bus.MemData, 16'hBEEF);
    check("post_destOut",  bus.destOut, 6);
    check("post_regWrOut", bus.regWrOut, 1);
    check("post_validOut", bus.validOut, 1);
    drive(1'b0, MEM_NONE, 16'h0, 16'h0, 8'h0, 3'd0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access.md
# mem_access

Memory-access stage of the LCA pipeline, directly upstream of write-back. It performs single-word loads and stores. It also sequences the multi-register load (LM) and store (SM) instructions, one register per cycle, stalling upstream stages until the transfer completes. Its registered outputs (`MemData`, `ALUOut`, destination register, write enable) are the operands the write-back stage selects from.

## Interface
Parameters: none. Data width is fixed at 16 bits; there are 8 architectural registers.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `validIn`  in  1  instruction present in this stage.
- `memOp`  in  3  0 none, 1 LW, 2 SW, 3 LM, 4 SM; values 5–7 are treated as none.
- `ALUIn`  in  16  effective address (LW/SW/LM/SM base) or ALU result.
- `storeData`  in  16  SW write data.
- `regList`  in  8  LM/SM register mask; bit i selects Ri.
- `destIn`  in  3  destination register for non-LM instructions.
- `regWrIn`  in  1  instruction writes a register (non-LM).
- `smRegAddr`  out  3  register-file read address used by SM.
- `smRegData`  in  16  register-file read data for `smRegAddr` (combinational).
- `memAddr`  out  16  data-memory address.
- `memWrData`  out  16  data-memory write data.
- `memWrEn`  out  1  data-memory write strobe.
- `memRdData`  in  16  data-memory read data (combinational read).
- `stall`  out  1  holds upstream stages; combinational.
- `MemData`  out  16  registered load data to write-back.
- `ALUOut`  out  16  registered `ALUIn` to write-back.
- `destOut`  out  3  registered destination register.
- `regWrOut`  out  1  registered register-write enable.
- `validOut`  out  1  registered valid.

## Operation
- **State machine.** States are IDLE and MULTI.
  - IDLE with a valid LW: `memAddr = ALUIn`. The next edge captures `MemData = memRdData`, `destOut = destIn` and `regWrOut = regWrIn`.
  - IDLE with a valid SW: `memAddr = ALUIn`, `memWrData = storeData`, `memWrEn = 1`. The next edge captures `regWrOut = 0`.
  - Any other valid op passes through in one cycle; `ALUOut`, `destOut` and `regWrOut` are copied.
- **LM/SM on entry.** The block transfers the lowest set bit i of `regList` at address `ALUIn`, with offset k = 0.
  - LM transfer: read the memory word, then register `MemData`, `destOut = i` and `regWrOut = 1`.
  - SM transfer: drive `smRegAddr = i`, `memWrData = smRegData`, `memWrEn = 1`; `regWrOut = 0`.
- **Remaining bits.** If further bits remain, the block latches the base address, the residual mask (bit i cleared), k = 1 and the op type. It then enters MULTI, asserting `stall` that cycle.
- **MULTI.** Each cycle transfers the lowest residual bit at address base+k, clears that bit and increments k.
  - `stall` is 1 unless this is the last bit.
  - On the last bit, `stall` is 0 and the state returns to IDLE.
  - Inputs other than `memRdData`/`smRegData` are ignored in MULTI.
- **Empty `regList`.** Behaves as a valid nop: one cycle, no memory write, `regWrOut = 0`.
- **Address arithmetic.** base+k wraps modulo 2^16.
- **Invalid input.** `validIn = 0` in IDLE produces `validOut = 0`, `regWrOut = 0` and `memWrEn = 0`.
- **Reset values.** Reset (asynchronous, active-low) forces: state IDLE, mask 0, k 0; `MemData`, `ALUOut`, `destOut`, `regWrOut` and `validOut` all 0. Reset asserted mid-LM/SM aborts the transfer; no further memory writes occur.
- **Combinational outputs under reset.** `memWrEn` and `stall` are gated to 0 while reset is asserted.

## Timing
- Latency is 1 cycle from input to registered outputs.
- LM/SM with n set bits occupies max(n,1) cycles:
  - `stall` is high for the first max(n,1)−1 of those cycles;
  - `validOut` pulses once per transferred register on the cycle after each transfer.
- Upstream must hold all inputs while `stall = 1`; the next instruction is accepted on the cycle `stall` is 0.
- Memory writes take effect at the edge ending the cycle in which `memWrEn = 1`.

## Structure
- **Shared package (`lca_pkg`):**
  - `memOp` encodings (`MEM_NONE`, `MEM_LW`, `MEM_SW`, `MEM_LM`, `MEM_SM`);
  - state encoding (`MA_IDLE`, `MA_MULTI`);
  - width constants (16-bit word, 3-bit register address).
- **Sub-module:** `prio_enc8` takes an 8-bit mask and returns the lowest set index (3 bits), a `none` flag, and a `single` flag (exactly one bit set). It is instantiated on the selected mask (`regList` in IDLE, residual in MULTI).

## Test plan
- **LW:** mem[0x0040] = 0xBEEF; LW with `ALUIn = 0x0040`, `destIn = 3` → next cycle `MemData = 0xBEEF`, `destOut = 3`, `regWrOut = 1`, `stall = 0`.
- **SW:** `ALUIn = 0x0100`, `storeData = 0x1234` → `memWrEn` high for one cycle, mem[0x0100] = 0x1234, `regWrOut = 0`.
- **LM:** `regList = 0xA5`, base 0x0040 → R0, R2, R5, R7 loaded from 0x0040–0x0043 over 4 cycles; `stall` = 1, 1, 1, 0; `destOut` sequence 0, 2, 5, 7.
- **SM wrap and single-bit:**
  - `regList = 0x07`, base 0xFFFE, R0..R2 = 0xA, 0xB, 0xC → mem[0xFFFE] = 0xA, mem[0xFFFF] = 0xB, mem[0x0000] = 0xC.
  - `regList = 0x80` → 1 cycle, `stall` never high.
- **Empty list:** LM with `regList = 0x00` → 1 cycle, `validOut = 1`, `regWrOut = 0`, no `memWrEn`.
- **Reset mid-transfer:** SM with `regList = 0xFF`, reset pulsed after the 3rd transfer → all outputs 0 immediately, mem[base+3..base+7] unchanged; after release, the block accepts a new LW normally.
